// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler -- single-rank DDR command scheduler, open-page policy.
//
// Accepts one read/write request at a time. It issues PRE/ACT as needed, then
// RD/WR, while enforcing tRCD/tRP/tRAS/tRFC. A periodic refresh is also issued
// every TREFI clocks, with all banks precharged first when any bank is open.
//
// Ports:
//   clk, rst                   sole clock (rising edge), synchronous active-high reset
//   req_valid/req_ready        request handshake (accepted when both high)
//   req_we, req_bg, req_ba,
//   req_row, req_col           request fields, captured on acceptance
//   cmd_done                   one-cycle pulse on the RD/WR(/RDA/WRA) issue cycle
//   busy                       FSM not in IDLE
//   cs_n, act_n, A, ba, bg     DDR command/address pins
//                              (A16 = RAS_n, A15 = CAS_n, A14 = WE_n, A10 = AP)
//   cke                        clock enable, low only while in reset
//
// Build option: define SCHED_AUTO_PRECHARGE_EN to issue RDA/WRA and close the
// bank after every access (closed-page policy).
module ddr_cmd_scheduler #(
  parameter int ADDRWIDTH     = 17,
  parameter int BANKGROUPS    = 4,
  parameter int BANKSPERGROUP = 4,
  parameter int COLS          = 1024,
  parameter int TRCD          = 4,
  parameter int TRP           = 4,
  parameter int TRAS          = 8,
  parameter int TRFC          = 16,
  parameter int TREFI         = 200,
  parameter int BGWIDTH       = (BANKGROUPS > 1) ? $clog2(BANKGROUPS) : 1,
  parameter int BAWIDTH       = (BANKSPERGROUP > 1) ? $clog2(BANKSPERGROUP) : 1,
  parameter int CADDRWIDTH    = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [BGWIDTH-1:0]    req_bg,
  input  logic [BAWIDTH-1:0]    req_ba,
  input  logic [ADDRWIDTH-1:0]  req_row,
  input  logic [CADDRWIDTH-1:0] req_col,
  output logic                  cmd_done,
  output logic                  busy,
  output logic                  cs_n,
  output logic                  act_n,
  output logic [ADDRWIDTH-1:0]  A,
  output logic [BAWIDTH:0]      ba,
  output logic [BGWIDTH:0]      bg,
  output logic                  cke
);

  localparam int NBANKS  = BANKGROUPS * BANKSPERGROUP;
  localparam int IDXW    = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int WMAX    = (TRFC > TRP) ? ((TRFC > TRCD) ? TRFC : TRCD)
                                        : ((TRP > TRCD) ? TRP : TRCD);
  localparam int WAITW   = $clog2(WMAX + 1);
  localparam int TRASW   = $clog2(TRAS + 1);
  localparam int REFW    = $clog2(TREFI + 1);
  localparam int RAS_BIT = 16;
  localparam int CAS_BIT = 15;
  localparam int WE_BIT  = 14;
  localparam int AP_BIT  = 10;

  typedef enum logic [2:0] {IDLE, PRE, ACT, CAS, REF_PRA, REF, WAIT} state_t;

  state_t state, state_next, wait_ret, wait_tgt;

  // Captured request
  logic                  cur_we;
  logic [BGWIDTH-1:0]    cur_bg;
  logic [BAWIDTH-1:0]    cur_ba;
  logic [ADDRWIDTH-1:0]  cur_row;
  logic [CADDRWIDTH-1:0] cur_col;

  // Per-bank open-page tracking
  logic [NBANKS-1:0]    bank_open;
  logic [ADDRWIDTH-1:0] open_row [NBANKS];
  logic [IDXW-1:0]      idx_in, cur_idx;
  logic                 any_open;

  logic             ref_pending;
  logic [REFW-1:0]  trefi_cnt;
  logic [TRASW-1:0] tras_cnt;
  logic             tras_ok;
  logic [WAITW-1:0] wait_cnt, wait_t;
  logic             cke_q;
  logic [BAWIDTH-1:0] ba_q;
  logic [BGWIDTH-1:0] bg_q;

  // FSM decode
  logic                 issue, act_cmd, bank_cmd, done_cmd, capture, go_wait;
  logic                 open_set, open_clr, open_clr_all, tras_restart, ref_clear;
  logic [ADDRWIDTH-1:0] a_cmd;
  logic                 cmd_en;

  assign idx_in   = IDXW'(req_bg) * IDXW'(BANKSPERGROUP) + IDXW'(req_ba);
  assign cur_idx  = IDXW'(cur_bg) * IDXW'(BANKSPERGROUP) + IDXW'(cur_ba);
  assign any_open = |bank_open;
  assign tras_ok  = (tras_cnt == '0);

  assign req_ready = (state == IDLE) && !ref_pending && cke_q;
  assign busy      = (state != IDLE);
  assign cke       = cke_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    issue        = 1'b0;
    act_cmd      = 1'b0;
    bank_cmd     = 1'b0;
    done_cmd     = 1'b0;
    capture      = 1'b0;
    go_wait      = 1'b0;
    wait_t       = WAITW'(1);
    wait_tgt     = IDLE;
    open_set     = 1'b0;
    open_clr     = 1'b0;
    open_clr_all = 1'b0;
    tras_restart = 1'b0;
    ref_clear    = 1'b0;
    a_cmd        = '0;
    case (state)
      IDLE: begin
        // Refresh outranks a request arriving in the same cycle.
        if (ref_pending) begin
          state_next = any_open ? REF_PRA : REF;
        end else if (req_valid && req_ready) begin
          capture = 1'b1;
          if (bank_open[idx_in])
            state_next = (open_row[idx_in] == req_row) ? CAS : PRE;
          else
            state_next = ACT;
        end
      end
      PRE: begin
        if (tras_ok) begin
          issue           = 1'b1;
          bank_cmd        = 1'b1;
          a_cmd[CAS_BIT]  = 1'b1;
          open_clr        = 1'b1;
          go_wait         = 1'b1;
          wait_t          = WAITW'(TRP);
          wait_tgt        = ACT;
        end
      end
      ACT: begin
        issue        = 1'b1;
        act_cmd      = 1'b1;
        bank_cmd     = 1'b1;
        a_cmd        = cur_row;
        open_set     = 1'b1;
        tras_restart = 1'b1;
        go_wait      = 1'b1;
        wait_t       = WAITW'(TRCD);
        wait_tgt     = CAS;
      end
      CAS: begin
        issue                   = 1'b1;
        bank_cmd                = 1'b1;
        done_cmd                = 1'b1;
        a_cmd[CADDRWIDTH-1:0]   = cur_col;
        a_cmd[RAS_BIT]          = 1'b1;
        a_cmd[WE_BIT]           = ~cur_we;
`ifdef SCHED_AUTO_PRECHARGE_EN
        a_cmd[AP_BIT]           = 1'b1;
        open_clr                = 1'b1;
        go_wait                 = 1'b1;
        wait_t                  = WAITW'(TRP);
        wait_tgt                = IDLE;
`else
        state_next              = IDLE;
`endif
      end
      REF_PRA: begin
        if (tras_ok) begin
          issue          = 1'b1;
          a_cmd[CAS_BIT] = 1'b1;
          a_cmd[AP_BIT]  = 1'b1;
          open_clr_all   = 1'b1;
          go_wait        = 1'b1;
          wait_t         = WAITW'(TRP);
          wait_tgt       = REF;
        end
      end
      REF: begin
        issue         = 1'b1;
        a_cmd[WE_BIT] = 1'b1;
        ref_clear     = 1'b1;
        go_wait       = 1'b1;
        wait_t        = WAITW'(TRFC);
        wait_tgt      = IDLE;
      end
      WAIT: begin
        if (wait_cnt == '0) state_next = wait_ret;
      end
      default: state_next = IDLE;
    endcase
    // A spacing of one clock needs no WAIT cycles at all.
    if (go_wait) state_next = (wait_t == WAITW'(1)) ? wait_tgt : WAIT;
  end

  // Pins decode straight from the current state; rst suppresses any command
  // still in flight so reset never lets it reach the bus.
  assign cmd_en   = issue & ~rst;
  assign cs_n     = ~cmd_en;
  assign act_n    = ~(act_cmd & ~rst);
  assign A        = cmd_en ? a_cmd : '0;
  assign cmd_done = done_cmd & ~rst;
  assign ba       = {1'b0, (bank_cmd && !rst) ? cur_ba : ba_q};
  assign bg       = {1'b0, (bank_cmd && !rst) ? cur_bg : bg_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      cke_q       <= 1'b0;
      ref_pending <= 1'b0;
      trefi_cnt   <= REFW'(TREFI);
      tras_cnt    <= '0;
      wait_cnt    <= '0;
      wait_ret    <= IDLE;
      bank_open   <= '0;
      ba_q        <= '0;
      bg_q        <= '0;
      cur_we      <= 1'b0;
      cur_bg      <= '0;
      cur_ba      <= '0;
      cur_row     <= '0;
      cur_col     <= '0;
    end else begin
      cke_q <= 1'b1;
      if (capture) begin
        cur_we  <= req_we;
        cur_bg  <= req_bg;
        cur_ba  <= req_ba;
        cur_row <= req_row;
        cur_col <= req_col;
      end
      // A new expiry wins over the clear from a REF issued in the same cycle.
      if (trefi_cnt == REFW'(1)) begin
        trefi_cnt   <= REFW'(TREFI);
        ref_pending <= 1'b1;
      end else begin
        trefi_cnt <= trefi_cnt - REFW'(1);
        if (ref_clear) ref_pending <= 1'b0;
      end
      if (tras_restart)    tras_cnt <= TRASW'(TRAS - 1);
      else if (!tras_ok)   tras_cnt <= tras_cnt - TRASW'(1);
      if (go_wait && wait_t != WAITW'(1)) begin
        wait_cnt <= wait_t - WAITW'(2);
        wait_ret <= wait_tgt;
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAITW'(1);
      end
      if (open_clr_all)  bank_open          <= '0;
      else if (open_set) bank_open[cur_idx] <= 1'b1;
      else if (open_clr) bank_open[cur_idx] <= 1'b0;
      if (bank_cmd) begin
        ba_q <= cur_ba;
        bg_q <= cur_bg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (open_set) open_row[cur_idx] <= cur_row;
  end

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Testbench for ddr_cmd_scheduler: directed scenarios followed by random
// traffic, all checked every cycle against a timeline reference model.
module tb_ddr_cmd_scheduler;
  localparam int TRCD  = 4;
  localparam int TRP   = 4;
  localparam int TRAS  = 8;
  localparam int TRFC  = 16;
  localparam int TREFI = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_bg = '0;
  logic [1:0]  req_ba = '0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        req_ready, cmd_done, busy, cs_n, act_n, cke;
  logic [16:0] A;
  logic [2:0]  ba, bg;

  always #5 clk = ~clk;

  ddr_cmd_scheduler #(
    .ADDRWIDTH(17), .BANKGROUPS(4), .BANKSPERGROUP(4), .COLS(1024),
    .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS), .TRFC(TRFC), .TREFI(TREFI)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .cmd_done(cmd_done), .busy(busy), .cs_n(cs_n),
    .act_n(act_n), .A(A), .ba(ba), .bg(bg), .cke(cke)
  );

  typedef struct {
    int          t;
    logic        act_n;
    logic [16:0] a;
    bit          has_bank;
    logic [1:0]  bg;
    logic [1:0]  ba;
    bit          done;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          n, idle_at, last_act, ref_clear_at;
  bit          pend, accepted;
  bit          mo_open [16];
  logic [16:0] mo_row  [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, n, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void push(input int t, input logic an, input logic [16:0] a,
                               input bit hb, input logic [1:0] g, input logic [1:0] b, input bit d);
    exp_t e;
    e.t = t; e.act_n = an; e.a = a; e.has_bank = hb; e.bg = g; e.ba = b; e.done = d;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    foreach (mo_open[i]) mo_open[i] = 1'b0;
    pend = 1'b0;
    n = 0;
    idle_at = 0;
    last_act = -TRAS;
    ref_clear_at = -1;
  endfunction

  // Timeline of one accepted request, starting the cycle after acceptance.
  function automatic void schedule_req(input int now);
    int idx = int'(req_bg) * 4 + int'(req_ba);
    int t = now + 1;
    logic [16:0] cas_a;
    if (!(mo_open[idx] && mo_row[idx] == req_row)) begin
      if (mo_open[idx]) begin
        t = imax(t, last_act + TRAS);
        push(t, 1'b1, 17'h08000, 1'b1, req_bg, req_ba, 1'b0);
        mo_open[idx] = 1'b0;
        t += TRP;
      end
      push(t, 1'b0, req_row, 1'b1, req_bg, req_ba, 1'b0);
      last_act = t;
      mo_open[idx] = 1'b1;
      mo_row[idx] = req_row;
      t += TRCD;
    end
    cas_a = 17'h10000 | (req_we ? 17'h00000 : 17'h04000) | {7'b0, req_col};
`ifdef SCHED_AUTO_PRECHARGE_EN
    cas_a = cas_a | 17'h00400;
    push(t, 1'b1, cas_a, 1'b1, req_bg, req_ba, 1'b1);
    mo_open[idx] = 1'b0;
    idle_at = t + TRP;
`else
    push(t, 1'b1, cas_a, 1'b1, req_bg, req_ba, 1'b1);
    idle_at = t + 1;
`endif
    accepted = 1'b1;
  endfunction

  function automatic void schedule_ref(input int now);
    int t = now + 1;
    bit any = 1'b0;
    foreach (mo_open[i]) any |= mo_open[i];
    if (any) begin
      t = imax(t, last_act + TRAS);
      push(t, 1'b1, 17'h08400, 1'b0, 2'b0, 2'b0, 1'b0);
      foreach (mo_open[i]) mo_open[i] = 1'b0;
      t += TRP;
    end
    push(t, 1'b1, 17'h04000, 1'b0, 2'b0, 2'b0, 1'b0);
    ref_clear_at = t + 1;
    idle_at = t + TRFC;
  endfunction

  // Advance one clock: let the model act on this cycle's inputs, then compare
  // the next cycle's outputs against the model.
  task automatic tick();
    exp_t e;
    logic cs_e, an_e, done_e;
    logic [16:0] a_e;
    if (n > 0 && n >= idle_at) begin
      if (pend)           schedule_ref(n);
      else if (req_valid) schedule_req(n);
    end
    @(posedge clk);
    #1;
    n++;
    if (n % TREFI == 0)        pend = 1'b1;
    else if (n == ref_clear_at) pend = 1'b0;
    cs_e = 1'b1; an_e = 1'b1; a_e = '0; done_e = 1'b0;
    e.has_bank = 1'b0; e.bg = '0; e.ba = '0;
    if (exp_q.size() > 0 && exp_q[0].t == n) begin
      e = exp_q.pop_front();
      cs_e = 1'b0; an_e = e.act_n; a_e = e.a; done_e = e.done;
    end
    chk("cmd_bus", {cs_n, act_n, A}, {cs_e, an_e, a_e});
    chk("status", {req_ready, busy, cmd_done, cke},
        {(n >= idle_at) && !pend, n < idle_at, done_e, 1'b1});
    if (e.has_bank) chk("bank", {bg, ba}, {1'b0, e.bg, 1'b0, e.ba});
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk("rst_cmd", {cs_n, act_n, A}, {1'b1, 1'b1, 17'h0});
      chk("rst_bank", {bg, ba}, 6'h0);
      chk("rst_status", {cke, req_ready, cmd_done, busy}, 4'b0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // Present a request and hold it until the model says it is taken.
  task automatic req(input bit we, input int g, input int b, input int row, input int col);
    req_we = we; req_bg = 2'(g); req_ba = 2'(b); req_row = 17'(row); req_col = 10'(col);
    req_valid = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 300 && !accepted; i++) tick();
    req_valid = 1'b0;
    chk("accept_bound", {63'b0, accepted}, 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && !(n >= idle_at && !pend && n > 0); i++) tick();
  endtask

  initial begin
    model_reset();
    do_reset(3);
    tick();
    // Read to a closed bank, then a row hit, then a row-miss write.
    req(1'b0, 1, 2, 'h155, 'h3A);
    wait_idle();
    req(1'b0, 1, 2, 'h155, 'h010);
    wait_idle();
    req(1'b1, 1, 2, 'h2AA, 'h3FF);
    wait_idle();
    req(1'b1, 3, 3, 'h1FFFF, 'h000);
    wait_idle();
    // Refresh with banks open; the request offered on the expiry cycle waits.
    while (n < TREFI) tick();
    req(1'b0, 3, 3, 'h1FFFF, 'h001);
    wait_idle();
    req(1'b0, 1, 2, 'h2AA, 'h020);
    wait_idle();
    // Reset one cycle after ACT: the read must never appear.
    req(1'b0, 0, 1, 'h0AB, 'h055);
    tick();
    do_reset(6);
    tick();
    req(1'b0, 0, 1, 'h0AB, 'h055);
    wait_idle();
    // Random traffic over a small bank/row set to get hits, misses and refreshes.
    for (int i = 0; i < 3000; i++) begin
      int sel = $urandom_range(0, 3);
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_bg    = 2'($urandom_range(0, 3));
      req_ba    = 2'($urandom_range(0, 1) * 2);
      req_col   = 10'($urandom_range(0, 1023));
      req_row   = (sel == 0) ? 17'h155 : (sel == 1) ? 17'h2AA : 17'($urandom_range(0, 131071));
      tick();
    end
    req_valid = 1'b0;
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
